// File: rtl/serial_mag_comp.sv
// Sequential MSB-first magnitude comparator that drives an external 2-bit comparator slice.
// One digit pair is compared per clock. It stops on the first unequal pair and registers a one-hot result.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [1:0]       slice_A,
  output logic [1:0]       slice_B,
  input  logic             slice_gt,
  input  logic             slice_eq,
  input  logic             slice_lt,
  output logic             busy,
  output logic             done,
  output logic             AgB,
  output logic             AeB,
  output logic             AlB
);
  localparam int S    = WIDTH / 2;
  localparam int IDXW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic {IDLE, RUN} stateT;

  stateT            stateReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [IDXW-1:0]  idxReg;
  logic [1:0]       aDigit [S];
  logic [1:0]       bDigit [S];
  logic             digitsEqual;

  generate
    for (genvar gi = 0; gi < S; gi++) begin : gDigit
      assign aDigit[gi] = aReg[2*gi +: 2];
      assign bDigit[gi] = bReg[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    slice_A = 2'b00;
    slice_B = 2'b00;
    if (stateReg == RUN) begin
      slice_A = aDigit[idxReg];
      slice_B = bDigit[idxReg];
    end
  end

  // A malformed all-zero slice result falls through gt/lt and is treated as equal.
  assign digitsEqual = slice_eq | ~(slice_gt | slice_lt);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      idxReg   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      AgB      <= 1'b0;
      AeB      <= 1'b0;
      AlB      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            aReg     <= A;
            bReg     <= B;
            idxReg   <= IDXW'(S - 1);
            AgB      <= 1'b0;
            AeB      <= 1'b0;
            AlB      <= 1'b0;
            busy     <= 1'b1;
            stateReg <= RUN;
          end
        end
        RUN: begin
          if (slice_gt) begin
            AgB      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            stateReg <= IDLE;
          end else if (slice_lt) begin
            AlB      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            stateReg <= IDLE;
          end else if (digitsEqual && idxReg == '0) begin
            AeB      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            stateReg <= IDLE;
          end else begin
            idxReg <= idxReg - 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp. The stimulus side pushes expected results when a start is accepted.
// A negedge monitor pops and checks them on done, and it also checks every digit pair that is driven.
module tb_serial_mag_comp;
  localparam int WIDTH = 8;
  localparam int S     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [1:0]       slice_A, slice_B;
  logic             slice_gt, slice_eq, slice_lt;
  logic             busy, done, AgB, AeB, AlB;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 2-bit comparator slice.
  assign slice_gt = (slice_A > slice_B);
  assign slice_eq = (slice_A == slice_B);
  assign slice_lt = (slice_A < slice_B);

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .slice_A(slice_A), .slice_B(slice_B),
    .slice_gt(slice_gt), .slice_eq(slice_eq), .slice_lt(slice_lt),
    .busy(busy), .done(done), .AgB(AgB), .AeB(AeB), .AlB(AlB)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               startEdge;
    int               lat;
    logic [2:0]       flags;
  } txnT;

  txnT sb[$];
  int  edgeCount = 0;
  int  lastEnd   = 0;
  int  total     = 0;
  int  bad       = 0;
  int  nTxn      = 0;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  // Result from plain comparison. Latency is the slice position of the highest differing bit.
  function automatic txnT model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, int e);
    txnT t;
    logic [WIDTH-1:0] x;
    int msb;
    x = a ^ b;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
    t.a = a;
    t.b = b;
    t.startEdge = e;
    t.flags = {a > b, a == b, a < b};
    t.lat = (msb < 0) ? S : S - msb / 2;
    return t;
  endfunction

  task automatic drive(bit s, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    @(negedge clk);
    start = s;
    A = a;
    B = b;
    if (s && !rst && (edgeCount + 1 > lastEnd)) begin
      txnT t;
      t = model(a, b, edgeCount + 1);
      sb.push_back(t);
      lastEnd = t.startEdge + t.lat;
      nTxn++;
      $display("txn %0d: A=%h B=%h expect gt/eq/lt=%b after %0d edges", nTxn, a, b, t.flags, t.lat);
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, WIDTH'($urandom), WIDTH'($urandom));
  endtask

  task automatic waitIdle();
    while (edgeCount < lastEnd + 1) idle(1);
  endtask

  task automatic applyReset(int n);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    sb.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    lastEnd = edgeCount;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", {AgB, AeB, AlB}, 0);
    check("reset_slices", {slice_A, slice_B}, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    txnT t;
    int k;
    if (!rst) begin
      if (sb.size() > 0 && edgeCount > sb[0].startEdge + sb[0].lat) begin
        check("done_seen", 0, 1);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          t = sb.pop_front();
          check("latency", edgeCount - t.startEdge, t.lat);
          check("result_flags", {AgB, AeB, AlB}, t.flags);
          check("busy_in_done", busy, 0);
        end
      end
      if (busy) begin
        check("flags_while_busy", {AgB, AeB, AlB}, 0);
        if (sb.size() == 0) begin
          check("unexpected_busy", 1, 0);
        end else begin
          k = S - 1 - (edgeCount - sb[0].startEdge);
          if (k >= 0)
            check("slice_pair", {slice_A, slice_B},
                  {2'((sb[0].a >> (2 * k)) & 3), 2'((sb[0].b >> (2 * k)) & 3)});
        end
      end else begin
        check("idle_slices", {slice_A, slice_B}, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    applyReset(3);
    idle(2);

    drive(1'b1, 8'hA5, 8'hA5); waitIdle();
    drive(1'b1, 8'h80, 8'h7F); waitIdle();
    drive(1'b1, 8'h12, 8'h13); waitIdle();

    // Starts while busy are ignored. A start in the done cycle is accepted.
    drive(1'b1, 8'h12, 8'h34);
    drive(1'b1, 8'hFF, 8'h00);
    drive(1'b1, 8'h00, 8'hFF);
    while (edgeCount + 1 < lastEnd) idle(1);
    drive(1'b1, 8'h3C, 8'h3D);
    idle(1);
    check("flags_after_restart", {AgB, AeB, AlB}, 0);
    check("busy_after_restart", busy, 1);
    waitIdle();

    // Reset two cycles into a compare abandons it without a done pulse.
    drive(1'b1, 8'h55, 8'h55);
    idle(1);
    applyReset(1);
    idle(5);
    drive(1'b1, 8'h00, 8'hC0); waitIdle();

    for (int i = 0; i < 300; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      drive($urandom_range(0, 9) < 6, ra, rb);
    end
    waitIdle();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Sequential N-bit magnitude comparator built around the existing 2-bit comparator slice.
- Loads two WIDTH-bit operands on a start pulse and walks them MSB-first, one 2-bit digit pair per clock.
- Drives the digit pair to an external 2-bit comparator instance and consumes its AgB/AeB/AlB result.
- Stops on the first unequal digit pair and registers a one-hot greater/equal/less result with a done pulse.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; number of slices S = WIDTH/2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
A  input  WIDTH  operand A, captured on accepted start.
B  input  WIDTH  operand B, captured on accepted start.
slice_A  output  2  current digit of A to the 2-bit comparator.
slice_B  output  2  current digit of B to the 2-bit comparator.
slice_gt  input  1  slice AgB from the 2-bit comparator (combinational).
slice_eq  input  1  slice AeB from the 2-bit comparator.
slice_lt  input  1  slice AlB from the 2-bit comparator.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse; result valid from this cycle.
AgB  output  1  registered result A > B.
AeB  output  1  registered result A == B.
AlB  output  1  registered result A < B.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clk edge) has priority over all other activity, including mid-compare:
  - state <- IDLE; busy, done, AgB, AeB and AlB <- 0; slice index <- 0; operand registers <- 0.
  - An in-flight compare is abandoned and done is never pulsed for it.
- States: IDLE, RUN.
- IDLE:
  - slice_A = slice_B = 0.
  - start=1 at an edge: capture A and B, set idx = S-1, clear AgB/AeB/AlB to 0, busy <- 1, go to RUN.
  - start=0: remain in IDLE; result flags hold.
- RUN:
  - slice_A = Areg[2*idx+1:2*idx] and slice_B = Breg[2*idx+1:2*idx], combinationally from registers.
  - Each edge evaluates the slice result with priority gt > lt > eq (covers a malformed slice input):
    - slice_gt=1: AgB <- 1, go to IDLE.
    - else slice_lt=1: AlB <- 1, go to IDLE.
    - else, with idx=0: AeB <- 1, go to IDLE.
    - else, with idx>0: idx <- idx-1, stay in RUN.
  - On leaving RUN: busy <- 0 and done <- 1 for exactly one cycle.
- Latency:
  - Start accepted at edge E0; slice k (MSB=S-1) is evaluated at edge E(S-k).
  - done is high in the cycle after the deciding edge: 1 edge for an MSB difference, S edges for equality or an LSB difference.
- Throughput:
  - start is ignored while busy=1; no queuing.
  - start=1 in the same cycle as done=1 is accepted, since the state is IDLE. Flags clear at that edge, so the result is visible only during the done cycle.
- Result flags:
  - Exactly one is high after done, held until the next accepted start or reset.
  - All are 0 while busy and after reset.
- A and B may change freely after the accepting edge; only the captured values are compared.

Test Plan:
- WIDTH=8, reset then idle: AgB=AeB=AlB=busy=done=0, slice_A=slice_B=0.
- A=0xA5, B=0xA5, start pulse: slices 10/10, 10/10, 01/01, 01/01 driven on successive cycles; done high 4 edges after the start edge; AeB=1, others 0.
- A=0x80, B=0x7F: first slice 10 vs 01 gives gt; done 1 edge after start; AgB=1; busy low in the done cycle.
- A=0x12, B=0x13: lt decided at the LSB slice (10 vs 11); done 4 edges after start; AlB=1.
- start re-pulsed while busy with different operands: ignored, and the original result is reported. Then start asserted in the done cycle: a new compare begins and flags read 0 the next cycle.
- rst asserted 2 cycles into a RUN: next cycle busy=0, all flags 0, no done pulse. A subsequent start with A=0x00, B=0xC0 yields AlB=1 after 1 edge.
